// File: rtl/approx_adder_pipe_pkg.sv
// Shared types and helpers for the segmented approximate adder pipeline.
package approx_pkg;

    localparam int ERR_W = 32;

    // Level tags travel down the pipe in a fixed-width field; LW must not exceed this.
    localparam int LVL_W = 8;

    function automatic int lw_of(input int width);
        return $clog2(width + 1);
    endfunction

    // Per-stage control payload; the partial sum rides in the shifting a/sum vector.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [LVL_W-1:0] level;
    } stage_ctl_t;

endpackage

// File: rtl/approx_adder_pipe_if.sv
// Operand/result handshake bundle for approx_adder_pipe.
interface approx_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LW    = approx_pkg::lw_of(16)
);

    logic             cfg_we;
    logic [LW-1:0]    cfg_lsbs;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output cfg_we, cfg_lsbs, in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  cfg_we, cfg_lsbs, in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/approx_adder_pipe_seg_add.sv
// One SEG_W-bit slice: lower-part OR below the level, exact ripple at and above it.
module approx_seg_add
    import approx_pkg::*;
#(
    parameter int SEG_W = 4
) (
    input  logic [LVL_W-1:0] i_base,
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic             i_cin,
    input  logic [LVL_W-1:0] i_level,
    output logic [SEG_W-1:0] o_sum,
    output logic             o_cout
);

    // The carry out of an OR bit is a&b, so bit L naturally sees a[L-1]&b[L-1].
    always_comb begin
        logic c;
        c     = i_cin;
        o_sum = '0;
        for (int j = 0; j < SEG_W; j++) begin
            if (int'(i_base) + j < int'(i_level)) begin
                o_sum[j] = i_a[j] | i_b[j];
                c        = i_a[j] & i_b[j];
            end else begin
                o_sum[j] = i_a[j] ^ i_b[j] ^ c;
                c        = (i_a[j] & i_b[j]) | (c & (i_a[j] ^ i_b[j]));
            end
        end
        o_cout = c;
    end

endmodule

// File: rtl/approx_adder_pipe.sv
// Pipelined approximate adder, one SEG_W slice per stage, valid/ready flow control.
// Define APPROX_ADDER_ERR_MON_EN to add the shadow exact sum and error counters.
module approx_adder_pipe
    import approx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4,
    parameter int LW    = lw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef APPROX_ADDER_ERR_MON_EN
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] err_abs_sum,
`endif
    approx_adder_pipe_if.slave bus
);

    localparam int NSEG = WIDTH / SEG_W;

    // Offset of stage k's leftover-B storage inside the flat delay vector.
    function automatic int bOff(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += WIDTH - (j + 1) * SEG_W;
        return s;
    endfunction

    localparam int BTOT = bOff(NSEG - 1);

    logic [LW-1:0]    r_level;
    logic             w_stall;
    logic             w_accept;
    logic [WIDTH-1:0] r_as  [NSEG];
    stage_ctl_t       r_ctl [NSEG];
    logic [BTOT-1:0]  r_bPipe;

    assign w_stall      = r_ctl[NSEG-1].valid && !bus.out_ready;
    assign bus.in_ready = !w_stall;
    assign w_accept     = bus.in_valid && !w_stall;

    assign bus.out_valid = r_ctl[NSEG-1].valid;
    assign bus.out_sum   = r_as[NSEG-1];
    assign bus.out_cout  = r_ctl[NSEG-1].carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_level <= '0;
        else if (bus.cfg_we)
            r_level <= (int'(bus.cfg_lsbs) > WIDTH) ? LW'(WIDTH) : bus.cfg_lsbs;
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int REM = WIDTH - k * SEG_W;

        logic [WIDTH-1:0] w_asIn;
        logic [REM-1:0]   w_bIn;
        stage_ctl_t       w_ctlIn;
        logic [SEG_W-1:0] w_segSum;
        logic             w_segCout;

        if (k == 0) begin : g_src
            assign w_asIn  = bus.in_a;
            assign w_bIn   = bus.in_b;
            assign w_ctlIn = '{valid: w_accept, carry: bus.in_cin, level: LVL_W'(r_level)};
        end else begin : g_src
            assign w_asIn  = r_as[k-1];
            assign w_bIn   = r_bPipe[bOff(k-1) +: REM];
            assign w_ctlIn = r_ctl[k-1];
        end

        approx_seg_add #(.SEG_W(SEG_W)) u_seg (
            .i_base  (LVL_W'(k * SEG_W)),
            .i_a     (w_asIn[SEG_W-1:0]),
            .i_b     (w_bIn[SEG_W-1:0]),
            .i_cin   (w_ctlIn.carry),
            .i_level (w_ctlIn.level),
            .o_sum   (w_segSum),
            .o_cout  (w_segCout)
        );

        // A consumes from the bottom while the sum fills from the top, so the vector
        // holds the finished sum after the last stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl[k] <= '0;
                r_as[k]  <= '0;
            end else if (!w_stall) begin
                r_ctl[k].valid <= w_ctlIn.valid;
                if (w_ctlIn.valid) begin
                    r_ctl[k].carry <= w_segCout;
                    r_ctl[k].level <= w_ctlIn.level;
                    r_as[k]        <= (w_asIn >> SEG_W) | (WIDTH'(w_segSum) << (WIDTH - SEG_W));
                end
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_bPipe[bOff(k) +: REM-SEG_W] <= '0;
                else if (!w_stall && w_ctlIn.valid)
                    r_bPipe[bOff(k) +: REM-SEG_W] <= w_bIn[REM-1:SEG_W];
            end
        end
    end

`ifdef APPROX_ADDER_ERR_MON_EN
    localparam int SW = ((WIDTH + 1 > ERR_W) ? WIDTH + 1 : ERR_W) + 1;

    logic [WIDTH:0]   r_exact [NSEG];
    logic [WIDTH:0]   w_approx;
    logic [WIDTH:0]   w_absErr;
    logic [SW-1:0]    w_sumWide;
    logic [ERR_W-1:0] r_errCount;
    logic [ERR_W-1:0] r_errAbsSum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEG; i++) r_exact[i] <= '0;
        end else if (!w_stall) begin
            if (w_accept)
                r_exact[0] <= {1'b0, bus.in_a} + {1'b0, bus.in_b} + (WIDTH+1)'(bus.in_cin);
            for (int i = 1; i < NSEG; i++)
                if (r_ctl[i-1].valid) r_exact[i] <= r_exact[i-1];
        end
    end

    assign w_approx  = {bus.out_cout, bus.out_sum};
    assign w_absErr  = (r_exact[NSEG-1] >= w_approx) ? r_exact[NSEG-1] - w_approx
                                                     : w_approx - r_exact[NSEG-1];
    assign w_sumWide = SW'(r_errAbsSum) + SW'(w_absErr);

    // Clear takes priority over a coincident output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount  <= '0;
            r_errAbsSum <= '0;
        end else if (err_clr) begin
            r_errCount  <= '0;
            r_errAbsSum <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (w_absErr != '0 && r_errCount != '1)
                r_errCount <= r_errCount + ERR_W'(1);
            r_errAbsSum <= (w_sumWide > SW'({ERR_W{1'b1}})) ? '1 : ERR_W'(w_sumWide);
        end
    end

    assign err_count   = r_errCount;
    assign err_abs_sum = r_errAbsSum;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed self-checking bench for approx_adder_pipe at WIDTH=16, SEG_W=4.
// Builds with or without APPROX_ADDER_ERR_MON_EN.
module tb_approx_adder_pipe;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   sent;
    int   got;
    int   stallLeft;

`ifdef APPROX_ADDER_ERR_MON_EN
    logic        err_clr;
    logic [31:0] err_count;
    logic [31:0] err_abs_sum;
`endif

    approx_adder_pipe_if #(.WIDTH(16), .LW(5)) bus ();

    approx_adder_pipe #(.WIDTH(16), .SEG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef APPROX_ADDER_ERR_MON_EN
        .err_clr     (err_clr),
        .err_count   (err_count),
        .err_abs_sum (err_abs_sum),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config mid-stream vectors: T0, T1 exact, T2 with 8 approximate LSBs.
    logic [15:0] cmA   [3] = '{16'h1234, 16'h0F0F, 16'h00FF};
    logic [15:0] cmB   [3] = '{16'h1111, 16'h0101, 16'h00FF};
    logic        cmC   [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] cmSum [3] = '{16'h2345, 16'h1011, 16'h01FF};

    // Backpressure stream, all exact.
    logic [15:0] bpA    [6] = '{16'h0001, 16'h1000, 16'hFFFF, 16'h8000, 16'h1234, 16'h00F0};
    logic [15:0] bpB    [6] = '{16'h0001, 16'h2000, 16'hFFFF, 16'h8000, 16'h4321, 16'h000F};
    logic        bpC    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] bpSum  [6] = '{16'h0002, 16'h3000, 16'hFFFF, 16'h0000, 16'h5555, 16'h0100};
    logic        bpCout [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLevel(input logic [4:0] lvl);
        bus.cfg_we   = 1'b1;
        bus.cfg_lsbs = lvl;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    // Single transaction with latency measurement; returns just after the output handshake.
    task automatic runOne(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] expSum, input logic expCout);
        int lat;
        applyStimulus(a, b, cin);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_lat"}, lat, 32'd4);
        checkOutput({tag, "_sum"}, 32'(bus.out_sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(bus.out_cout), 32'(expCout));
        tick();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_lsbs   = '0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_cin     = 1'b0;
        bus.out_ready  = 1'b1;
`ifdef APPROX_ADDER_ERR_MON_EN
        err_clr        = 1'b0;
`endif
        #2;
        $display("[TB] checking reset state");
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("rst_out_cout", 32'(bus.out_cout), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        tick();
`ifdef APPROX_ADDER_ERR_MON_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`endif

        // Level register comes out of reset at 0, so no configuration here.
        $display("[TB] exact mode");
        runOne("exact", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

        $display("[TB] approximate mode L=4");
        setLevel(5'd4);
        runOne("approx4", 16'h00FF, 16'h0001, 1'b1, 16'h00FF, 1'b0);
`ifdef APPROX_ADDER_ERR_MON_EN
        checkOutput("err_count", err_count, 32'd1);
        checkOutput("err_abs_sum", err_abs_sum, 32'd2);
`endif

        $display("[TB] full approximation, level saturates");
        setLevel(5'd20);
        runOne("approx16", 16'h8001, 16'h8100, 1'b0, 16'h8101, 1'b1);

        $display("[TB] config change mid-stream");
        setLevel(5'd0);
        applyStimulus(cmA[0], cmB[0], cmC[0]);
        tick();
        applyStimulus(cmA[1], cmB[1], cmC[1]);
        bus.cfg_we   = 1'b1;
        bus.cfg_lsbs = 5'd8;
        tick();
        bus.cfg_we = 1'b0;
        applyStimulus(cmA[2], cmB[2], cmC[2]);
        tick();
        bus.in_valid = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checkOutput($sformatf("cm_sum%0d", got), 32'(bus.out_sum), 32'(cmSum[got]));
                checkOutput($sformatf("cm_cout%0d", got), 32'(bus.out_cout), 32'd0);
                got++;
            end
            tick();
        end
        checkOutput("cm_count", got, 32'd3);

        $display("[TB] backpressure stream");
        setLevel(5'd0);
        sent      = 0;
        got       = 0;
        stallLeft = 3;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (sent < 6) applyStimulus(bpA[sent], bpB[sent], bpC[sent]);
            else bus.in_valid = 1'b0;
            if (bus.out_valid && stallLeft > 0) begin
                bus.out_ready = 1'b0;
                stallLeft--;
            end else begin
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (!bus.out_ready) begin
                checkOutput("bp_in_ready_stall", 32'(bus.in_ready), 32'd0);
                checkOutput("bp_hold_sum", 32'(bus.out_sum), 32'(bpSum[got]));
                checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            end else if (bus.out_valid) begin
                checkOutput($sformatf("bp_sum%0d", got), 32'(bus.out_sum), 32'(bpSum[got]));
                checkOutput($sformatf("bp_cout%0d", got), 32'(bus.out_cout), 32'(bpCout[got]));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("bp_stalls_seen", stallLeft, 32'd0);
        checkOutput("bp_sent", sent, 32'd6);
        checkOutput("bp_got", got, 32'd6);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            checkOutput("bp_no_extra", 32'(bus.out_valid), 32'd0);
            tick();
        end

        $display("[TB] reset mid-flight");
        setLevel(5'd8);
        applyStimulus(16'h0001, 16'h0001, 1'b0);
        tick();
        applyStimulus(16'h0002, 16'h0002, 1'b0);
        tick();
        applyStimulus(16'h0003, 16'h0003, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checkOutput("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("mid_rst_cout", 32'(bus.out_cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            checkOutput("mid_no_stale", 32'(bus.out_valid), 32'd0);
            tick();
        end
        // With L back at 0 this is exact (0x01FE); a surviving L=8 would give 0x01FF.
        runOne("post_rst", 16'h00FF, 16'h00FF, 1'b0, 16'h01FE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
